line_sensor_emu: RTL and testbench

Synthesizable line-scan sensor and quadrature-encoder emulator for bench and on-board bring-up of the scanner pipeline. It sits in place of the analog front end: it answers each SI start-of-line pulse from the sensor controller with a dark interval and a run of pixel words on every channel. It also generates a free-running quadrature encoder. Width, pixel count, dark length, channel count, pattern mode, ADC code format and encoder direction are all configurable.

---
 rtl/line_sensor_emu.sv | 167 ++++++++++++++++
 tb/tb_line_sensor_emu.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_sensor_emu.sv
// Line-scan sensor and quadrature encoder emulator: answers each SI start-of-line
// pulse with a dark interval followed by PIX_CNT pixel words on every channel.
module line_sensor_emu #(
    parameter int DW         = 12,
    parameter int CHANNELS   = 3,
    parameter int PIX_CNT    = 2592,
    parameter int DARK_CYC   = 89,
    parameter int ENC_PERIOD = 5000,
    parameter bit OFFSET_BIN = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   si_i,
    input  logic [1:0]             mode_i,
    input  logic                   enc_en_i,
    input  logic                   dir_i,
    output logic [CHANNELS*DW-1:0] data_o,
    output logic                   dvalid_o,
    output logic                   line_busy_o,
    output logic [15:0]            line_cnt_o,
    output logic                   overrun_o,
    output logic [1:0]             enc_o
);

    localparam int PW = (PIX_CNT > 1) ? $clog2(PIX_CNT) : 1;
    localparam int KW = (DARK_CYC > 1) ? $clog2(DARK_CYC) : 1;
    localparam int EW = $clog2(ENC_PERIOD);

    localparam logic [DW-1:0]          FLIP      = OFFSET_BIN ? {1'b1, {(DW-1){1'b0}}} : '0;
    localparam logic [CHANNELS*DW-1:0] IDLE_WORD = {CHANNELS{FLIP}};
    localparam logic [PW-1:0]          LAST_PIX  = PW'(PIX_CNT - 1);
    localparam logic [KW-1:0]          DARK_LOAD = KW'(DARK_CYC - 1);
    localparam logic [EW-1:0]          ENC_TC    = EW'(ENC_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DARK, ACTIVE} state_e;

    state_e                 state_q, state_d;
    logic                   si_q, si_prev_q;
    logic                   si_rise;
    logic [KW-1:0]          dark_q, dark_d;
    logic [PW-1:0]          pix_q, pix_d;
    logic [1:0]             mode_q, mode_d;
    logic [15:0]            lcnt_q, lcnt_d;
    logic                   ovr_q, ovr_d;
    logic [CHANNELS*DW-1:0] data_q, data_d;
    logic                   dvalid_q, dvalid_d;
    logic [EW-1:0]          ecnt_q, ecnt_d;
    logic [1:0]             enc_q, enc_d;

    // Raw pixel value before the output code conversion.
    function automatic logic [DW-1:0] pixel_value(input logic [1:0] mode,
                                                  input logic [PW-1:0] pix,
                                                  input logic [15:0] lcnt,
                                                  input int ch);
        logic [DW-1:0] v;
        case (mode)
            2'd0:    v = DW'(pix) + DW'(ch + 1);
            2'd1:    v = ((((32'(pix) >> 3) & 32'd1) != 32'd0) ^ lcnt[0]) ? '1 : '0;
            2'd2:    v = {1'b0, {(DW-1){1'b1}}};
            default: v = DW'(lcnt) + DW'(ch);
        endcase
        return v;
    endfunction

    assign si_rise = si_q & ~si_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            si_q      <= 1'b0;
            si_prev_q <= 1'b0;
            state_q   <= IDLE;
            dark_q    <= '0;
            pix_q     <= '0;
            mode_q    <= '0;
            lcnt_q    <= '0;
            ovr_q     <= 1'b0;
            data_q    <= IDLE_WORD;
            dvalid_q  <= 1'b0;
            ecnt_q    <= '0;
            enc_q     <= 2'b00;
        end else begin
            si_q      <= si_i;
            si_prev_q <= si_q;
            state_q   <= state_d;
            dark_q    <= dark_d;
            pix_q     <= pix_d;
            mode_q    <= mode_d;
            lcnt_q    <= lcnt_d;
            ovr_q     <= ovr_d;
            data_q    <= data_d;
            dvalid_q  <= dvalid_d;
            ecnt_q    <= ecnt_d;
            enc_q     <= enc_d;
        end
    end

    // A rise during the final pixel is a clean back-to-back start, not an overrun.
    always_comb begin
        state_d = state_q;
        dark_d  = dark_q;
        pix_d   = pix_q;
        mode_d  = mode_q;
        lcnt_d  = lcnt_q;
        ovr_d   = ovr_q;
        if (!en_i) begin
            state_d = IDLE;
        end else if (si_rise) begin
            if (state_q == DARK || (state_q == ACTIVE && pix_q != LAST_PIX))
                ovr_d = 1'b1;
            state_d = DARK;
            dark_d  = DARK_LOAD;
            lcnt_d  = lcnt_q + 16'd1;
            mode_d  = mode_i;
        end else begin
            case (state_q)
                DARK: begin
                    if (dark_q == '0) begin
                        state_d = ACTIVE;
                        pix_d   = '0;
                    end else begin
                        dark_d = dark_q - KW'(1);
                    end
                end
                ACTIVE: begin
                    if (pix_q == LAST_PIX)
                        state_d = IDLE;
                    else
                        pix_d = pix_q + PW'(1);
                end
                default: ;
            endcase
        end
    end

    // Output words are built from next state so DATA and DVALID register together.
    always_comb begin
        data_d   = IDLE_WORD;
        dvalid_d = (state_d == ACTIVE);
        if (state_d == ACTIVE) begin
            for (int c = 0; c < CHANNELS; c++)
                data_d[c*DW +: DW] = pixel_value(mode_d, pix_d, lcnt_d, c) ^ FLIP;
        end
    end

    // ENC is held in a register so each step flips exactly one output bit.
    always_comb begin
        ecnt_d = ecnt_q;
        enc_d  = enc_q;
        if (enc_en_i) begin
            if (ecnt_q == ENC_TC) begin
                ecnt_d = '0;
                enc_d  = dir_i ? {~enc_q[0], enc_q[1]} : {enc_q[0], ~enc_q[1]};
            end else begin
                ecnt_d = ecnt_q + EW'(1);
            end
        end
    end

    assign data_o      = data_q;
    assign dvalid_o    = dvalid_q;
    assign line_busy_o = (state_q != IDLE);
    assign line_cnt_o  = lcnt_q;
    assign overrun_o   = ovr_q;
    assign enc_o       = enc_q;

endmodule

// File: tb/tb_line_sensor_emu.sv
// Scoreboard bench for line_sensor_emu: two instances differing only in output code
// format, expected pixel words queued at SI time and popped by a negedge monitor.
module tb_line_sensor_emu;

    localparam int DW   = 12;
    localparam int CH   = 3;
    localparam int PIX  = 2592;
    localparam int DARK = 89;
    localparam int EPER = 5000;
    localparam logic [CH*DW-1:0] IDLE1 = {CH{12'h800}};
    localparam logic [CH*DW-1:0] IDLE0 = '0;

    logic clk = 1'b0;
    logic rstN, en, si, encEn, dir;
    logic [1:0] mode;

    logic [CH*DW-1:0] data1, data0;
    logic dvalid1, dvalid0, busy1, busy0, ovr1, ovr0;
    logic [15:0] lcnt1, lcnt0;
    logic [1:0] enc1, enc0;

    int checks, errors, expLc;
    bit monOn;
    logic [CH*DW-1:0] expQ1[$];
    logic [CH*DW-1:0] expQ0[$];
    logic [CH*DW-1:0] expW1, expW0;

    line_sensor_emu #(.DW(DW), .CHANNELS(CH), .PIX_CNT(PIX), .DARK_CYC(DARK),
                      .ENC_PERIOD(EPER), .OFFSET_BIN(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rstN), .en_i(en), .si_i(si), .mode_i(mode),
        .enc_en_i(encEn), .dir_i(dir), .data_o(data1), .dvalid_o(dvalid1),
        .line_busy_o(busy1), .line_cnt_o(lcnt1), .overrun_o(ovr1), .enc_o(enc1));

    line_sensor_emu #(.DW(DW), .CHANNELS(CH), .PIX_CNT(PIX), .DARK_CYC(DARK),
                      .ENC_PERIOD(EPER), .OFFSET_BIN(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rstN), .en_i(en), .si_i(si), .mode_i(mode),
        .enc_en_i(encEn), .dir_i(dir), .data_o(data0), .dvalid_o(dvalid0),
        .line_busy_o(busy0), .line_cnt_o(lcnt0), .overrun_o(ovr0), .enc_o(enc0));

    always #5 clk = ~clk;

    function automatic logic [CH*DW-1:0] expWord(input logic [1:0] m, input int p,
                                                 input int lc, input bit off);
        logic [CH*DW-1:0] w;
        int v;
        w = '0;
        for (int c = 0; c < CH; c++) begin
            case (m)
                2'd0:    v = (p + 1 + c) % 4096;
                2'd1:    v = ((((p >> 3) & 1) ^ (lc & 1)) != 0) ? 4095 : 0;
                2'd2:    v = 2047;
                default: v = (lc + c) % 4096;
            endcase
            if (off) v = v ^ 2048;
            w[c*DW +: DW] = v[DW-1:0];
        end
        return w;
    endfunction

    function automatic logic [1:0] encSeq(input int idx);
        case (idx % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic pushLine(input logic [1:0] m, input int lc);
        for (int p = 0; p < PIX; p++) begin
            expQ1.push_back(expWord(m, p, lc, 1'b1));
            expQ0.push_back(expWord(m, p, lc, 1'b0));
        end
    endtask

    // Pops one expected word per valid cycle; idle cycles must carry the idle code.
    always @(negedge clk) begin
        if (monOn) begin
            checks++;
            if (dvalid1) begin
                if (expQ1.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_pixel1 got %h want no pixel", data1);
                end else begin
                    expW1 = expQ1.pop_front();
                    if (data1 !== expW1) begin
                        errors++;
                        $display("[TB] FAIL pixel1 got %h want %h", data1, expW1);
                    end
                end
            end else if (data1 !== IDLE1) begin
                errors++;
                $display("[TB] FAIL idle1 got %h want %h", data1, IDLE1);
            end
            checks++;
            if (dvalid0) begin
                if (expQ0.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_pixel0 got %h want no pixel", data0);
                end else begin
                    expW0 = expQ0.pop_front();
                    if (data0 !== expW0) begin
                        errors++;
                        $display("[TB] FAIL pixel0 got %h want %h", data0, expW0);
                    end
                end
            end else if (data0 !== IDLE0) begin
                errors++;
                $display("[TB] FAIL idle0 got %h want %h", data0, IDLE0);
            end
        end
    end

    task automatic waitFirstValid(input string tag);
        int n;
        n = 0;
        while (dvalid1 !== 1'b1 && n < DARK + 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dvalid1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_timeout dvalid got %b want 1", tag, dvalid1);
        end
    endtask

    task automatic countValid(output int nValid);
        nValid = 0;
        while (dvalid1 === 1'b1 && nValid < PIX + 20) begin
            nValid++;
            @(negedge clk);
        end
    endtask

    task automatic flushQueues();
        expQ1.delete();
        expQ0.delete();
    endtask

    // One full line from IDLE with the SI-to-pixel timing checked cycle by cycle.
    task automatic runLine(input logic [1:0] m, input bit holdSi, input bit flipMode,
                           output logic [CH*DW-1:0] fw1, output logic [CH*DW-1:0] fw0);
        int nValid;
        @(negedge clk);
        mode = m; si = 1'b1; expLc++; pushLine(m, expLc);
        @(negedge clk);
        if (!holdSi) si = 1'b0;
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL busy_early got %b want 0", busy1); end
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("[TB] FAIL busy_rise got %b want 1", busy1); end
        repeat (DARK - 1) @(negedge clk);
        checks++;
        if (dvalid1 !== 1'b0) begin errors++; $display("[TB] FAIL dvalid_early got %b want 0", dvalid1); end
        @(negedge clk);
        checks++;
        if (dvalid1 !== 1'b1) begin errors++; $display("[TB] FAIL dvalid_first got %b want 1", dvalid1); end
        fw1 = data1;
        fw0 = data0;
        if (flipMode) mode = ~m;
        countValid(nValid);
        checks++;
        if (nValid != PIX) begin errors++; $display("[TB] FAIL valid_count got %0d want %0d", nValid, PIX); end
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL busy_fall got %b want 0", busy1); end
        checks++;
        if (expQ1.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_left got %0d want 0", expQ1.size()); end
        checks++;
        if (lcnt1 !== 16'(expLc)) begin errors++; $display("[TB] FAIL line_cnt got %0d want %0d", lcnt1, expLc); end
        flushQueues();
    endtask

    task automatic test_reset();
        #2 rstN = 1'b0;
        #3;
        checks++;
        if (data1 !== IDLE1) begin errors++; $display("[TB] FAIL reset_data1 got %h want %h", data1, IDLE1); end
        checks++;
        if (data0 !== IDLE0) begin errors++; $display("[TB] FAIL reset_data0 got %h want %h", data0, IDLE0); end
        checks++;
        if ({dvalid1, busy1, ovr1, dvalid0, busy0, ovr0} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b want 000000", {dvalid1, busy1, ovr1, dvalid0, busy0, ovr0});
        end
        checks++;
        if (lcnt1 !== 16'd0 || lcnt0 !== 16'd0) begin errors++; $display("[TB] FAIL reset_line_cnt got %0d/%0d want 0", lcnt1, lcnt0); end
        checks++;
        if (enc1 !== 2'b00 || enc0 !== 2'b00) begin errors++; $display("[TB] FAIL reset_enc got %b/%b want 00", enc1, enc0); end
        repeat (2) @(negedge clk);
        rstN = 1'b1; en = 1'b1; expLc = 0; monOn = 1'b1;
    endtask

    task automatic test_mode3_line_id();
        logic [CH*DW-1:0] f1, f0;
        for (int ln = 1; ln <= 3; ln++) begin
            runLine(2'd3, 1'b0, ln == 3, f1, f0);
            checks++;
            if ((f1[DW-1:0] ^ 12'h800) !== 12'(ln)) begin
                errors++;
                $display("[TB] FAIL line_id got %0d want %0d", f1[DW-1:0] ^ 12'h800, ln);
            end
        end
        mode = 2'd0;
    endtask

    task automatic test_ramp_line();
        logic [CH*DW-1:0] f1, f0;
        runLine(2'd0, 1'b0, 1'b0, f1, f0);
        checks++;
        if (f1[11:0] !== 12'h801 || f1[23:12] !== 12'h802) begin
            errors++;
            $display("[TB] FAIL ramp_first got %h/%h want 801/802", f1[11:0], f1[23:12]);
        end
    endtask

    task automatic test_offset_format();
        logic [CH*DW-1:0] f1, f0;
        runLine(2'd2, 1'b0, 1'b0, f1, f0);
        checks++;
        if (f1[11:0] !== 12'hFFF || f0[11:0] !== 12'h7FF) begin
            errors++;
            $display("[TB] FAIL midlevel got %h/%h want fff/7ff", f1[11:0], f0[11:0]);
        end
        checks++;
        if (data1 !== IDLE1 || data0 !== IDLE0) begin
            errors++;
            $display("[TB] FAIL idle_after_line got %h/%h want %h/%h", data1, data0, IDLE1, IDLE0);
        end
    endtask

    task automatic test_checker_line();
        logic [CH*DW-1:0] f1, f0;
        runLine(2'd1, 1'b0, 1'b0, f1, f0);
    endtask

    task automatic test_back_to_back();
        int gap, nValid;
        @(negedge clk);
        mode = 2'd0; si = 1'b1; expLc++; pushLine(2'd0, expLc);
        @(negedge clk);
        si = 1'b0;
        waitFirstValid("b2b_first");
        repeat (PIX - 2) @(negedge clk);
        checks++;
        if (dvalid1 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_penultimate got %b want 1", dvalid1); end
        si = 1'b1; expLc++; pushLine(2'd0, expLc);
        @(negedge clk);
        si = 1'b0;
        @(negedge clk);
        checks++;
        if ({dvalid1, ovr1, busy1} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL b2b_restart got dvalid/ovr/busy %b want 001", {dvalid1, ovr1, busy1});
        end
        gap = 1;
        while (gap < DARK + 10) begin
            @(negedge clk);
            if (dvalid1 === 1'b1) break;
            gap++;
        end
        checks++;
        if (gap != DARK) begin errors++; $display("[TB] FAIL b2b_gap got %0d want %0d", gap, DARK); end
        countValid(nValid);
        checks++;
        if (nValid != PIX) begin errors++; $display("[TB] FAIL b2b_count got %0d want %0d", nValid, PIX); end
        checks++;
        if (lcnt1 !== 16'(expLc)) begin errors++; $display("[TB] FAIL b2b_line_cnt got %0d want %0d", lcnt1, expLc); end
        flushQueues();
    endtask

    task automatic test_si_held();
        logic [CH*DW-1:0] f1, f0;
        runLine(2'd2, 1'b1, 1'b0, f1, f0);
        repeat (20) @(negedge clk);
        checks++;
        if (lcnt1 !== 16'(expLc) || busy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL si_held got cnt %0d busy %b want %0d 0", lcnt1, busy1, expLc);
        end
        si = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_enable();
        @(negedge clk);
        mode = 2'd0; si = 1'b1; expLc++; pushLine(2'd0, expLc);
        @(negedge clk);
        si = 1'b0;
        waitFirstValid("en_first");
        repeat (49) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (dvalid1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL en_abort got dvalid %b busy %b want 0 0", dvalid1, busy1);
        end
        checks++;
        if (expQ1.size() != PIX - 50) begin
            errors++;
            $display("[TB] FAIL en_abort_pixels got %0d left want %0d", expQ1.size(), PIX - 50);
        end
        flushQueues();
        si = 1'b1;
        @(negedge clk);
        si = 1'b0;
        repeat (DARK + 20) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || lcnt1 !== 16'(expLc)) begin
            errors++;
            $display("[TB] FAIL en_ignore got busy %b cnt %0d want 0 %0d", busy1, lcnt1, expLc);
        end
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_overrun();
        int startLc, nValid;
        startLc = expLc;
        @(negedge clk);
        mode = 2'd0; si = 1'b1; expLc++; pushLine(2'd0, expLc);
        @(negedge clk);
        si = 1'b0;
        waitFirstValid("ovr_first");
        repeat (99) @(negedge clk);
        si = 1'b1; expLc++;
        @(negedge clk);
        si = 1'b0;
        @(negedge clk);
        checks++;
        if ({dvalid1, ovr1, busy1} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL ovr_restart got dvalid/ovr/busy %b want 011", {dvalid1, ovr1, busy1});
        end
        checks++;
        if (expQ1.size() != PIX - 101) begin
            errors++;
            $display("[TB] FAIL ovr_pixels got %0d left want %0d", expQ1.size(), PIX - 101);
        end
        flushQueues();
        pushLine(2'd0, expLc);
        repeat (DARK - 1) @(negedge clk);
        checks++;
        if (dvalid1 !== 1'b0) begin errors++; $display("[TB] FAIL ovr_gap got %b want 0", dvalid1); end
        @(negedge clk);
        checks++;
        if (dvalid1 !== 1'b1) begin errors++; $display("[TB] FAIL ovr_first_pixel got %b want 1", dvalid1); end
        countValid(nValid);
        checks++;
        if (nValid != PIX) begin errors++; $display("[TB] FAIL ovr_count got %0d want %0d", nValid, PIX); end
        checks++;
        if (lcnt1 !== 16'(startLc + 2) || ovr1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovr_sticky got cnt %0d ovr %b want %0d 1", lcnt1, ovr1, startLc + 2);
        end
        flushQueues();
    endtask

    task automatic test_encoder();
        int idx;
        idx = 0;
        dir = 1'b0;
        @(negedge clk);
        encEn = 1'b1;
        for (int s = 0; s < 5; s++) begin
            if (s == 4) dir = 1'b1;
            repeat (EPER - 1) @(negedge clk);
            checks++;
            if (enc1 !== encSeq(idx)) begin errors++; $display("[TB] FAIL enc_hold got %b want %b", enc1, encSeq(idx)); end
            @(negedge clk);
            idx = (s == 4) ? idx + 3 : idx + 1;
            checks++;
            if (enc1 !== encSeq(idx)) begin errors++; $display("[TB] FAIL enc_step got %b want %b", enc1, encSeq(idx)); end
        end
        repeat (1234) @(negedge clk);
        encEn = 1'b0;
        for (int i = 0; i < 7; i++) begin
            repeat (1000) @(negedge clk);
            checks++;
            if (enc1 !== encSeq(idx)) begin errors++; $display("[TB] FAIL enc_disabled got %b want %b", enc1, encSeq(idx)); end
        end
        encEn = 1'b1;
        repeat (EPER - 1234 - 1) @(negedge clk);
        checks++;
        if (enc1 !== encSeq(idx)) begin errors++; $display("[TB] FAIL enc_resume_hold got %b want %b", enc1, encSeq(idx)); end
        @(negedge clk);
        idx = idx + 3;
        checks++;
        if (enc1 !== encSeq(idx)) begin errors++; $display("[TB] FAIL enc_resume_step got %b want %b", enc1, encSeq(idx)); end
        encEn = 1'b0;
    endtask

    task automatic test_reset_midline();
        logic [CH*DW-1:0] f1, f0;
        @(negedge clk);
        mode = 2'd1; si = 1'b1; expLc++; pushLine(2'd1, expLc);
        @(negedge clk);
        si = 1'b0;
        waitFirstValid("rst_first");
        repeat (30) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checks++;
        if (data1 !== IDLE1 || dvalid1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_data got %h dvalid %b want %h 0", data1, dvalid1, IDLE1);
        end
        checks++;
        if (lcnt1 !== 16'd0 || ovr1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_status got cnt %0d ovr %b busy %b want 0 0 0", lcnt1, ovr1, busy1);
        end
        checks++;
        if (enc1 !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_enc got %b want 00", enc1); end
        flushQueues();
        expLc = 0;
        @(negedge clk);
        rstN = 1'b1;
        runLine(2'd3, 1'b0, 1'b0, f1, f0);
        checks++;
        if (f1[DW-1:0] !== 12'h801) begin errors++; $display("[TB] FAIL rst_recover_id got %h want 801", f1[DW-1:0]); end
    endtask

    initial begin
        checks = 0; errors = 0; expLc = 0; monOn = 1'b0;
        rstN = 1'b1; en = 1'b0; si = 1'b0; mode = 2'd0; encEn = 1'b0; dir = 1'b0;
        test_reset();
        test_mode3_line_id();
        test_ramp_line();
        test_offset_format();
        test_checker_line();
        test_back_to_back();
        test_si_held();
        test_enable();
        test_overrun();
        test_encoder();
        test_reset_midline();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
